// File: rtl/pes_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding and
// positions of the one-hot result flags.
package pes_cmp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned ResLt = 0;
    localparam int unsigned ResEq = 1;
    localparam int unsigned ResGt = 2;
    localparam int unsigned ResW  = 3;

endpackage

// File: rtl/pes_cmp2_slice.sv
// Purely combinational 2-bit unsigned magnitude comparator with one-hot
// less/equal/greater outputs.
module pes_cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    always_comb begin
        lt = (a < b);
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/pes_serial_cmp_ctrl.sv
// Serial unsigned comparator: walks the captured operands MSB-first, one 2-bit
// slice per cycle through a single shared slice comparator, stopping early.
module pes_serial_cmp_ctrl
    import pes_cmp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    localparam int unsigned NSLICE = DATA_W / 2,
    localparam int unsigned CNT_W  = $clog2(NSLICE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              a_less_b,
    output logic              a_equal_b,
    output logic              a_greater_b,
    output logic [CNT_W-1:0]  slices_used,
    output logic              busy
);

    localparam int unsigned IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ResW-1:0]     flags_q, flags_d;

    // Operands viewed as arrays of 2-bit slices so idx can select one directly.
    logic [NSLICE-1:0][1:0] a_sl;
    logic [NSLICE-1:0][1:0] b_sl;
    logic                   s_lt, s_eq, s_gt;

    assign a_sl = a_q;
    assign b_sl = b_q;

    pes_cmp2_slice u_slice (
        .a  (a_sl[idx_q]),
        .b  (b_sl[idx_q]),
        .lt (s_lt),
        .eq (s_eq),
        .gt (s_gt)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = ~rst;
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_W'(NSLICE - 1);
                    cnt_d   = '0;
                    flags_d = '0;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (!s_eq) begin
                    flags_d[ResLt] = s_lt;
                    flags_d[ResGt] = s_gt;
                    state_d        = StDone;
                end else if (idx_q == '0) begin
                    flags_d[ResEq] = 1'b1;
                    state_d        = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    assign a_less_b    = flags_q[ResLt];
    assign a_equal_b   = flags_q[ResEq];
    assign a_greater_b = flags_q[ResGt];
    assign slices_used = cnt_q;

endmodule

// File: tb/tb_pes_serial_cmp_ctrl.sv
// Self-checking bench: directed vector table, hand-written reset/hold sequences,
// random operands against an arithmetic model, and an exhaustive 2-bit instance.
module tb_pes_serial_cmp_ctrl;

    localparam int NSL = 4;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b;
    logic       lt, eq, gt, busy;
    logic [2:0] su;

    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [1:0] a2, b2;
    logic       lt2, eq2, gt2, busy2;
    logic [0:0] su2;

    int total = 0;
    int bad   = 0;

    pes_serial_cmp_ctrl #(.DATA_W(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a_less_b    (lt),
        .a_equal_b   (eq),
        .a_greater_b (gt),
        .slices_used (su),
        .busy        (busy)
    );

    pes_serial_cmp_ctrl #(.DATA_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .a           (a2),
        .b           (b2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .a_less_b    (lt2),
        .a_equal_b   (eq2),
        .a_greater_b (gt2),
        .slices_used (su2),
        .busy        (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain comparison, and the slice count is how far down from the
    // MSB the highest differing 2-bit slice sits.
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                  output logic elt, output logic eeq, output logic egt,
                                  output int ek);
        int xa, xb;
        xa  = int'(ma);
        xb  = int'(mb);
        elt = (xa < xb);
        eeq = (xa == xb);
        egt = (xa > xb);
        ek  = NSL;
        for (int s = 0; s < NSL; s++) begin
            if (((xa >> (2 * s)) & 3) != ((xb >> (2 * s)) & 3)) ek = NSL - s;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("excl_valid_ready", 32'(out_valid & in_ready), 32'd0);
            if (out_valid) check("onehot", 32'($countones({lt, eq, gt})), 32'd1);
            if (out_valid2) check("onehot2", 32'($countones({lt2, eq2, gt2})), 32'd1);
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb,
                         input logic elt, input logic eeq, input logic egt, input int ek,
                         input int stall, input string tag);
        int  lat;
        bit  seen;
        wait_ready();
        a         = ta;
        b         = tb;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~ta;
        b        = 8'($urandom);
        check({tag, " ovalid_after_accept"}, 32'(out_valid), 32'd0);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= NSL + 4; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
        end
        if (!seen) begin
            check({tag, " result_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, " latency"}, 32'(lat), 32'(ek));
        check({tag, " lt"}, 32'(lt), 32'(elt));
        check({tag, " eq"}, 32'(eq), 32'(eeq));
        check({tag, " gt"}, 32'(gt), 32'(egt));
        check({tag, " slices"}, 32'(su), 32'(ek));
        if (stall > 0) begin
            in_valid = 1'b1;
            for (int s = 0; s < stall; s++) begin
                a = 8'($urandom);
                b = 8'($urandom);
                @(posedge clk);
                #1;
                check({tag, " hold_ovalid"}, 32'(out_valid), 32'd1);
                check({tag, " hold_flags"}, 32'({lt, eq, gt}), 32'({elt, eeq, egt}));
                check({tag, " hold_slices"}, 32'(su), 32'(ek));
                check({tag, " hold_inready"}, 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " ovalid_drop"}, 32'(out_valid), 32'd0);
        check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, " flags_after"}, 32'({lt, eq, gt}), 32'({elt, eeq, egt}));
        check({tag, " slices_after"}, 32'(su), 32'(ek));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       lt;
        logic       eq;
        logic       gt;
        int         k;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic elt, eeq, egt;
        int   ek;
        logic [7:0] ra, rb;

        vecs[0] = '{8'hA5, 8'h25, 1'b0, 1'b0, 1'b1, 1};
        vecs[1] = '{8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 4};
        vecs[2] = '{8'h40, 8'h41, 1'b1, 1'b0, 1'b0, 4};
        vecs[3] = '{8'hC0, 8'h80, 1'b0, 1'b0, 1'b1, 1};
        vecs[4] = '{8'h34, 8'h38, 1'b1, 1'b0, 1'b0, 3};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 4};
        vecs[7] = '{8'h1F, 8'h0F, 1'b0, 1'b0, 1'b1, 2};
        vecs[8] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 4};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        a2         = '0;
        b2         = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_inready", 32'(in_ready), 32'd0);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({lt, eq, gt}), 32'd0);
        check("rst_slices", 32'(su), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_inready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].lt, vecs[i].eq, vecs[i].gt, vecs[i].k,
                  0, $sformatf("vec%0d", i));
        end

        do_op(8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1, 5, "hold");

        // Reset in the middle of a compare must abort with no partial result.
        wait_ready();
        a        = 8'h01;
        b        = 8'h02;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_inready_in_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_ovalid", 32'(out_valid), 32'd0);
        check("abort_flags", 32'({lt, eq, gt}), 32'd0);
        check("abort_slices", 32'(su), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_inready", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_result", 32'(out_valid), 32'd0);
        do_op(8'h02, 8'h01, 1'b0, 1'b0, 1'b1, 4, 0, "after_abort");

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            model(ra, rb, elt, eeq, egt, ek);
            do_op(ra, rb, elt, eeq, egt, ek, ($urandom_range(0, 3) == 0) ? 2 : 0,
                  $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        for (int i = 0; i < 16; i++) begin
            a2        = 2'(i >> 2);
            b2        = 2'(i & 3);
            in_valid2 = 1'b1;
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            check($sformatf("w2_%0d early", i), 32'(out_valid2), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("w2_%0d ovalid", i), 32'(out_valid2), 32'd1);
            check($sformatf("w2_%0d flags", i), 32'({lt2, eq2, gt2}),
                  32'({((i >> 2) < (i & 3)), ((i >> 2) == (i & 3)), ((i >> 2) > (i & 3))}));
            check($sformatf("w2_%0d slices", i), 32'(su2), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("w2_%0d drop", i), 32'(out_valid2), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
